// File: rtl/fp_int_to_fp.sv
// fp_int_to_fp: three-stage pipelined signed integer to packed float converter.
//
// Output format is {sign, exp[NX], mant[NM]} with bias 2^(NX-1)-1. An all-ones
// exponent means infinity. Rounding is round-to-nearest, ties-to-even.
//
// Stages: S1 sign/magnitude, S2 normalise, S3 round and pack (S3 is the output).
// Each stage advances when it is empty or the stage after it advances.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          synchronous active-high reset, clears all stage valid bits
//   in_valid     in_int is valid
//   in_ready     S1 can accept in_int this cycle (combinational on out_ready)
//   in_int       signed two's-complement integer, NI bits
//   out_valid    out_fp is valid
//   out_ready    consumer accepts out_fp this cycle
//   out_inexact  (only with FP_ITOF_INEXACT_EN) result was rounded or overflowed
//   out_fp       converted value, NX+NM+1 bits
//
// Optional feature macro: FP_ITOF_INEXACT_EN adds the out_inexact port.

module fp_int_to_fp #(
    parameter int unsigned NX = 8,
    parameter int unsigned NM = 23,
    parameter int unsigned NI = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NI-1:0]   in_int,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef FP_ITOF_INEXACT_EN
    output logic            out_inexact,
`endif
    output logic [NX+NM:0]  out_fp
);

    // Width of an unbiased exponent / bit index into the magnitude.
    localparam int unsigned LW = $clog2(NI) + 1;
    // Fraction field width: at least NM so narrow integers zero-fill on the right.
    localparam int unsigned FW = (NI - 1 > NM) ? NI - 1 : NM;
    // Biased exponent width, wide enough that e + bias + carry never wraps.
    localparam int unsigned EW = ((NX > LW) ? NX : LW) + 2;
    localparam logic [EW-1:0] Bias   = EW'((2 ** (NX - 1)) - 1);
    localparam logic [EW-1:0] ExpMax = EW'((2 ** NX) - 1);

    // Handshake / stage advance
    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic s1_adv, s2_adv, s3_adv;

    always_comb begin
        s3_adv = !s3_valid_q || out_ready;
        s2_adv = !s2_valid_q || s3_adv;
        s1_adv = !s1_valid_q || s2_adv;
    end

    assign in_ready  = s1_adv;
    assign out_valid = s3_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid;
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s3_adv) s3_valid_q <= s2_valid_q;
        end
    end

    // S1: sign / magnitude. Negating the most negative value yields 2^(NI-1),
    // which is exactly right when the result is read as unsigned.
    logic          s1_sign_q;
    logic [NI-1:0] s1_mag_d, s1_mag_q;

    always_comb begin
        s1_mag_d = in_int[NI-1] ? (~in_int + NI'(1)) : in_int;
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_sign_q <= in_int[NI-1];
            s1_mag_q  <= s1_mag_d;
        end
    end

    // S2: normalise. e = index of the leading one = NI-1-lz.
    // The MSB of norm doubles as the nonzero flag: it is 0 only when mag == 0.
    logic          s2_sign_q;
    logic [LW-1:0] s1_msb, s2_exp_q;
    logic [NI-1:0] s2_norm_d, s2_norm_q;

    always_comb begin
        s1_msb = '0;
        for (int i = 0; i < NI; i++) begin
            if (s1_mag_q[i]) s1_msb = LW'(i);
        end
        s2_norm_d = s1_mag_q << (LW'(NI - 1) - s1_msb);
    end

    always_ff @(posedge clk) begin
        if (s2_adv && s1_valid_q) begin
            s2_sign_q <= s1_sign_q;
            s2_exp_q  <= s1_msb;
            s2_norm_q <= s2_norm_d;
        end
    end

    // S3: round and pack
    logic [FW-1:0]   s3_frac;
    logic [FW+1:0]   s3_frac_x;
    logic [NM-1:0]   s3_mant;
    logic            s3_guard, s3_sticky, s3_round_up, s3_ovf;
    logic [NM:0]     s3_mant_r;
    logic [EW-1:0]   s3_exp_b;
    logic [NX+NM:0]  s3_fp_d;
    logic [NX+NM:0]  out_fp_q;

    always_comb begin
        // Left-align the bits below the hidden one; two extra zero LSBs keep the
        // guard and sticky slices non-empty even when nothing is discarded.
        s3_frac     = FW'(s2_norm_q[NI-2:0]) << (FW - (NI - 1));
        s3_frac_x   = {s3_frac, 2'b00};
        s3_mant     = s3_frac_x[FW+1 -: NM];
        s3_guard    = s3_frac_x[FW+1-NM];
        s3_sticky   = |s3_frac_x[FW-NM:0];
        s3_round_up = s3_guard && (s3_sticky || s3_mant[0]);
        // A carry out leaves the low NM bits at zero, as required.
        s3_mant_r   = {1'b0, s3_mant} + {{NM{1'b0}}, s3_round_up};
        s3_exp_b    = EW'(s2_exp_q) + Bias + EW'(s3_mant_r[NM]);
        s3_ovf      = (s3_exp_b >= ExpMax);

        if (!s2_norm_q[NI-1]) begin
            s3_fp_d = '0;
        end else if (s3_ovf) begin
            s3_fp_d = {s2_sign_q, {NX{1'b1}}, {NM{1'b0}}};
        end else begin
            s3_fp_d = {s2_sign_q, s3_exp_b[NX-1:0], s3_mant_r[NM-1:0]};
        end
    end

`ifdef FP_ITOF_INEXACT_EN
    logic s3_inexact_d, out_inexact_q;

    always_comb begin
        s3_inexact_d = s2_norm_q[NI-1] && (s3_guard || s3_sticky || s3_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_inexact_q <= 1'b0;
        end else if (s3_adv && s2_valid_q) begin
            out_inexact_q <= s3_inexact_d;
        end
    end

    assign out_inexact = out_inexact_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_fp_q <= '0;
        end else if (s3_adv && s2_valid_q) begin
            out_fp_q <= s3_fp_d;
        end
    end

    assign out_fp = out_fp_q;

endmodule

// File: tb/tb_fp_int_to_fp.sv
// Directed bench for fp_int_to_fp: a default single-precision instance and a
// half-precision-shaped instance (NX=5, NM=10) for the overflow vectors.
module tb_fp_int_to_fp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_int;
    logic [31:0] out_fp;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [31:0] in_int2;
    logic [15:0] out_fp2;

`ifdef FP_ITOF_INEXACT_EN
    logic out_inexact, out_inexact2;
`endif

    int checks = 0;
    int errors = 0;

    fp_int_to_fp #(.NX(8), .NM(23), .NI(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_int     (in_int),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef FP_ITOF_INEXACT_EN
        .out_inexact(out_inexact),
`endif
        .out_fp     (out_fp)
    );

    fp_int_to_fp #(.NX(5), .NM(10), .NI(32)) dut_h (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .in_int     (in_int2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
`ifdef FP_ITOF_INEXACT_EN
        .out_inexact(out_inexact2),
`endif
        .out_fp     (out_fp2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_int = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_int2 = '0; out_ready2 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_fp !== 32'h0) begin
            errors++; $display("FAIL reset_out_fp: got %h want 00000000", out_fp);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (out_valid2 !== 1'b0 || out_fp2 !== 16'h0 || in_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_half: got v=%b fp=%h rdy=%b want v=0 fp=0000 rdy=1",
                     out_valid2, out_fp2, in_ready2);
        end
`ifdef FP_ITOF_INEXACT_EN
        checks++;
        if (out_inexact !== 1'b0) begin
            errors++; $display("FAIL reset_inexact: got %b want 0", out_inexact);
        end
`endif
    endtask

    // 1, -1, 0 back to back; first result visible 3 cycles after the transfer.
    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_int = 32'd1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_lat1: got valid %b want 0", out_valid);
        end
        in_int = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_lat2: got valid %b want 0", out_valid);
        end
        in_int = 32'd0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_fp !== 32'h3F80_0000) begin
            errors++; $display("FAIL b2b_one: got v=%b %h want v=1 3f800000", out_valid, out_fp);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_fp !== 32'hBF80_0000) begin
            errors++; $display("FAIL b2b_neg_one: got v=%b %h want v=1 bf800000", out_valid, out_fp);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_fp !== 32'h0000_0000) begin
            errors++; $display("FAIL b2b_zero: got v=%b %h want v=1 00000000", out_valid, out_fp);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got valid %b want 0", out_valid);
        end
    endtask

    // Rounding and extremes on the default instance.
    task automatic test_rounding();
        logic [31:0] vals [6];
        logic [31:0] exps [6];
        logic        inex [6];
        int n_in, n_out;
        logic xfer;
        vals[0] = 32'd16777217;  exps[0] = 32'h4B80_0000; inex[0] = 1'b1;
        vals[1] = 32'd16777219;  exps[1] = 32'h4B80_0002; inex[1] = 1'b1;
        vals[2] = 32'h7FFF_FFFF; exps[2] = 32'h4F00_0000; inex[2] = 1'b1;
        vals[3] = 32'h8000_0000; exps[3] = 32'hCF00_0000; inex[3] = 1'b0;
        vals[4] = 32'h00FF_FFFF; exps[4] = 32'h4B7F_FFFF; inex[4] = 1'b0;
        vals[5] = 32'hFFFF_FFFD; exps[5] = 32'hC040_0000; inex[5] = 1'b0;
        n_in = 0; n_out = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && n_out < 6; cyc++) begin
            in_valid = (n_in < 6);
            if (n_in < 6) in_int = vals[n_in];
            #1;
            xfer = in_valid && in_ready;
            if (out_valid) begin
                checks++;
                if (out_fp !== exps[n_out]) begin
                    errors++;
                    $display("FAIL round_%0d: got %h want %h", n_out, out_fp, exps[n_out]);
                end
`ifdef FP_ITOF_INEXACT_EN
                checks++;
                if (out_inexact !== inex[n_out]) begin
                    errors++;
                    $display("FAIL round_inexact_%0d: got %b want %b", n_out, out_inexact,
                             inex[n_out]);
                end
`endif
                n_out++;
            end
            tick();
            if (xfer) n_in++;
        end
        in_valid = 1'b0;
        checks++;
        if (n_out != 6) begin
            errors++; $display("FAIL round_timeout: got %0d results want 6", n_out);
        end
    endtask

    // Overflow vectors on the NX=5, NM=10 instance.
    task automatic test_overflow();
        logic [31:0] vals [3];
        logic [15:0] exps [3];
        logic        inex [3];
        int n_in, n_out;
        logic xfer;
        vals[0] = 32'd65504;     exps[0] = 16'h7BFF; inex[0] = 1'b0;
        vals[1] = 32'd65520;     exps[1] = 16'h7C00; inex[1] = 1'b1;
        vals[2] = 32'hFFFE_7960; exps[2] = 16'hFC00; inex[2] = 1'b1;
        n_in = 0; n_out = 0;
        out_ready2 = 1'b1;
        for (int cyc = 0; cyc < 30 && n_out < 3; cyc++) begin
            in_valid2 = (n_in < 3);
            if (n_in < 3) in_int2 = vals[n_in];
            #1;
            xfer = in_valid2 && in_ready2;
            if (out_valid2) begin
                checks++;
                if (out_fp2 !== exps[n_out]) begin
                    errors++;
                    $display("FAIL ovf_%0d: got %h want %h", n_out, out_fp2, exps[n_out]);
                end
`ifdef FP_ITOF_INEXACT_EN
                checks++;
                if (out_inexact2 !== inex[n_out]) begin
                    errors++;
                    $display("FAIL ovf_inexact_%0d: got %b want %b", n_out, out_inexact2,
                             inex[n_out]);
                end
`endif
                n_out++;
            end
            tick();
            if (xfer) n_in++;
        end
        in_valid2 = 1'b0;
        checks++;
        if (n_out != 3) begin
            errors++; $display("FAIL ovf_timeout: got %0d results want 3", n_out);
        end
    endtask

    // 100..107 streamed while out_ready follows a fixed irregular pattern.
    // Expected: 100.0 = 0x42C80000, each +1 adds 0x20000 in this binade.
    task automatic test_backpressure();
        logic [63:0] pat;
        int n_in, n_out;
        logic xin, xout, stalled, exp_rdy;
        logic [31:0] prev_fp, want;
        pat = 64'hFFFF_FFFF_8C35_A1E2;
        n_in = 0; n_out = 0;
        for (int cyc = 0; cyc < 64 && n_out < 8; cyc++) begin
            out_ready = pat[cyc];
            in_valid = (n_in < 8);
            in_int = 32'(100 + n_in);
            #1;
            exp_rdy = !((n_in - n_out) == 3 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL bp_in_ready_c%0d: got %b want %b", cyc, in_ready, exp_rdy);
            end
            xin = in_valid && in_ready;
            xout = out_valid && out_ready;
            if (xout) begin
                want = 32'h42C8_0000 + 32'(n_out) * 32'h0002_0000;
                checks++;
                if (out_fp !== want) begin
                    errors++; $display("FAIL bp_order_%0d: got %h want %h", n_out, out_fp, want);
                end
            end
            stalled = out_valid && !out_ready;
            prev_fp = out_fp;
            tick();
            if (xin) n_in++;
            if (xout) n_out++;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_fp !== prev_fp) begin
                    errors++;
                    $display("FAIL bp_stall_c%0d: got v=%b %h want v=1 %h", cyc, out_valid,
                             out_fp, prev_fp);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (n_out != 8) begin
            errors++; $display("FAIL bp_timeout: got %0d results want 8", n_out);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_duplicate: got valid %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        int seen;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_int = 32'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_fp !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got v=%b fp=%h rdy=%b want v=0 fp=00000000 rdy=1",
                     out_valid, out_fp, in_ready);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL mid_stale: got %0d stale results want 0", seen);
        end
        // Pipeline still converts after the flush: 7 -> 0x40E00000.
        in_valid = 1'b1; in_int = 32'd7;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_fp !== 32'h40E0_0000) begin
            errors++;
            $display("FAIL mid_after: got v=%b %h want v=1 40e00000", out_valid, out_fp);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_rounding();
        test_overflow();
        test_backpressure();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
